regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised 2-read/1-write register file with per-register pending (scoreboard) bits,
//  optional write-to-read bypass, optional hardwired-zero R0, and a sequential clear engine.
//  Sits in the decode stage: feeds operands to the ALU and tells the issue logic whether an
//  operand's producer has not yet written back.
// PARAMETERS
//  DATA_W    19            register/data width in bits
//  ADDR_W    4             register address width
//  NUM_REGS  1<<ADDR_W     number of registers (<= 2**ADDR_W)
//  ZERO_REG  1             1: R0 reads 0, ignores writes, never pending
//  BYPASS    1             1: same-cycle write data forwarded to matching read port
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst_n      in   1        synchronous active-low reset
//  rd_addr1   in   ADDR_W   read port 1 address
//  rd_data1   out  DATA_W   read port 1 data (combinational)
//  rd_busy1   out  1        pending bit for rd_addr1 (combinational)
//  rd_addr2   in   ADDR_W   read port 2 address
//  rd_data2   out  DATA_W   read port 2 data (combinational)
//  rd_busy2   out  1        pending bit for rd_addr2 (combinational)
//  wr_en      in   1        writeback strobe
//  wr_addr    in   ADDR_W   writeback register
//  wr_data    in   DATA_W   writeback data
//  iss_en     in   1        issue strobe: mark iss_addr pending
//  iss_addr   in   ADDR_W   destination register of issued instruction
//  clr_req    in   1        start sequential clear (1-cycle pulse or level)
//  clr_busy   out  1        high while clear engine runs
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all regs 0, all pending 0, FSM IDLE, clear counter 0,
//    clr_busy 0. Reset mid-clear aborts clear; array fully zeroed regardless.
//  - Storage exactly DATA_W per entry; no truncation/extension anywhere.
//  - Write: wr_en=1 in IDLE -> reg[wr_addr]<=wr_data and pending[wr_addr]<=0 at edge.
//  - Issue: iss_en=1 in IDLE -> pending[iss_addr]<=1 at edge. Same edge iss & wr to same
//    addr: data written AND pending ends 1 (new producer wins).
//  - Addr >= NUM_REGS: writes/issues ignored; reads return 0, busy 0.
//  - ZERO_REG=1: addr 0 writes/issues ignored; reads 0, busy 0 (bypass never applies).
//  - Read (IDLE, BYPASS=1): if wr_en & wr_addr==rd_addrN -> rd_dataN=wr_data, rd_busyN=0;
//    else rd_dataN=reg[rd_addrN], rd_busyN=pending[rd_addrN]. BYPASS=0: array value only,
//    new data visible the cycle after the write edge. Both ports may use same address.
//  - FSM IDLE->CLEAR on clr_req=1 in IDLE; clr_busy=1 from next cycle. CLEAR: each cycle
//    reg[cnt]<=0, pending[cnt]<=0, cnt++; after cnt==NUM_REGS-1 -> IDLE, cnt<=0.
//    Clear takes exactly NUM_REGS cycles. In CLEAR: wr_en, iss_en, clr_req ignored; bypass
//    off; reads return current array (partly cleared); rd_busyN=1 for all addresses.
// TESTING
//  1 Reset: write R3=0x7FFFF, assert rst_n=0 one cycle -> rd_data1(R3)=0, rd_busy1=0.
//  2 Bypass: wr_en R5=0x12345, rd_addr1=5 same cycle -> rd_data1=0x12345, rd_busy1=0;
//    repeat with BYPASS=0 -> old value 0 until next cycle.
//  3 Scoreboard: iss R7 -> next cycle rd_busy2=1; wr R7=0x00042 -> next cycle busy 0;
//    iss+wr R7 same edge -> data 0x00042 stored, busy stays 1.
//  4 Zero reg: wr R0=0x5A5A5, iss R0 -> rd_data=0, rd_busy=0.
//  5 Clear: fill all 16 regs, pulse clr_req -> clr_busy high 16 cycles, wr_en during clear
//    has no effect, all regs 0 and pending 0 after; reset at cycle 8 -> IDLE, all 0.
//  6 Params DATA_W=32, ADDR_W=5, NUM_REGS=24: R23 write/read 0xFFFFFFFF ok; R24 write
//    ignored, read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: 2R/1W register file with per-register pending bits, optional
// write->read bypass, optional zero R0 and a one-register-per-cycle clear engine.
// Ports: clk, rst_n (sync, active low); rd_addr1/2 -> rd_data1/2, rd_busy1/2;
// wr_en/wr_addr/wr_data writeback; iss_en/iss_addr mark pending; clr_req -> clr_busy.
module regfile_mp #(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [ADDR_W-1:0] cnt;
  logic idle, clearing, cnt_last;
  logic wr_ok, iss_ok;

  assign cnt_last = (cnt == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (clr_req)  state_nx = S_CLEAR;
      S_CLEAR: if (cnt_last) state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    idle     = (state == S_IDLE);
    clearing = (state == S_CLEAR);
    clr_busy = clearing;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        cnt <= '0;
    else if (clearing) cnt <= cnt_last ? '0 : cnt + ADDR_W'(1);
  end

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign wr_ok  = idle && wr_en  && !is_zero(wr_addr);
  assign iss_ok = idle && iss_en && !is_zero(iss_addr);

  // Out-of-range addresses never match an entry, so they drop out here.
  // Issue is applied after write so a same-edge issue leaves the reg pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        mem[i]  <= '0;
        pend[i] <= 1'b0;
      end else if (clearing) begin
        if (cnt == ADDR_W'(i)) begin
          mem[i]  <= '0;
          pend[i] <= 1'b0;
        end
      end else begin
        if (wr_ok && wr_addr == ADDR_W'(i)) begin
          mem[i]  <= wr_data;
          pend[i] <= 1'b0;
        end
        if (iss_ok && iss_addr == ADDR_W'(i))
          pend[i] <= 1'b1;
      end
    end
  end

  // Returns {busy, data} for one read port.
  function automatic logic [DATA_W:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    logic b;
    d = '0;
    b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) begin
        d = mem[i];
        b = pend[i];
      end
    end
    if (is_zero(a)) begin
      d = '0;
      b = 1'b0;
    end else if (BYPASS != 0 && idle && wr_en &&
                 wr_addr == a && in_range(a)) begin
      d = wr_data;
      b = 1'b0;
    end
    // Nothing is safe to issue against while the array is being wiped.
    if (clearing) b = 1'b1;
    return {b, d};
  endfunction

  assign {rd_busy1, rd_data1} = rd_port(rd_addr1);
  assign {rd_busy2, rd_data2} = rd_port(rd_addr2);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random checks of regfile_mp against an
// array-based model; a second instance covers the 32/5/24, no-bypass build.
module tb_regfile_mp;

  localparam int DW = 19;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data;
  logic rd_busy1, rd_busy2, wr_en, iss_en, clr_req, clr_busy;

  logic [4:0]  b_rd_addr1, b_rd_addr2, b_wr_addr, b_iss_addr;
  logic [31:0] b_rd_data1, b_rd_data2, b_wr_data;
  logic b_rd_busy1, b_rd_busy2, b_wr_en, b_iss_en, b_clr_req, b_clr_busy;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(b_rd_addr1), .rd_data1(b_rd_data1), .rd_busy1(b_rd_busy1),
    .rd_addr2(b_rd_addr2), .rd_data2(b_rd_data2), .rd_busy2(b_rd_busy2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays, a clearing flag and a walk index.
  logic [DW-1:0] m_reg [NR];
  logic          m_pend [NR];
  bit            m_clr;
  int            m_cnt;

  function automatic logic [DW:0] m_read(input logic [AW-1:0] a);
    if (m_clr) return {1'b1, m_reg[a]};
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return {1'b0, wr_data};
    return {m_pend[a], m_reg[a]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_clr = 0;
      m_cnt = 0;
    end else if (m_clr) begin
      m_reg[m_cnt] = '0;
      m_pend[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == NR) begin
        m_clr = 0;
        m_cnt = 0;
      end
    end else begin
      if (clr_req) m_clr = 1;
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  end

  logic [DW:0] e1, e2;

  always @(negedge clk) begin
    if (chk_en) begin
      e1 = m_read(rd_addr1);
      e2 = m_read(rd_addr2);
      chk("rd_data1", 32'(rd_data1), 32'(e1[DW-1:0]));
      chk("rd_busy1", 32'(rd_busy1), 32'(e1[DW]));
      chk("rd_data2", 32'(rd_data2), 32'(e2[DW-1:0]));
      chk("rd_busy2", 32'(rd_busy2), 32'(e2[DW]));
      chk("clr_busy", 32'(clr_busy), 32'(m_clr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 0; iss_en = 0; clr_req = 0;
    b_wr_en = 0; b_iss_en = 0; b_clr_req = 0;
  endtask

  task automatic fill_and_issue();
    for (int i = 0; i < NR; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i * 32'h1111 + 1);
      tick();
    end
    wr_en = 0;
    for (int i = 1; i < NR; i += 2) begin
      iss_en = 1; iss_addr = AW'(i);
      tick();
    end
    iss_en = 0;
  endtask

  task automatic check_all_zero(input string nm);
    for (int i = 0; i < NR; i++) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(i);
      #1;
      chk({nm, "_data"}, 32'(rd_data1), 32'h0);
      chk({nm, "_busy"}, 32'(rd_busy2), 32'h0);
    end
  endtask

  int n;

  initial begin
    idle_in();
    rd_addr1 = 0; rd_addr2 = 0; wr_addr = 0; iss_addr = 0; wr_data = 0;
    b_rd_addr1 = 0; b_rd_addr2 = 0; b_wr_addr = 0; b_iss_addr = 0;
    b_wr_data = 0;
    tick(); tick();
    rst_n = 1;
    chk_en = 1;
    #1;
    chk("reset_clr_busy", 32'(clr_busy), 32'h0);

    // Reset wipes data
    wr_en = 1; wr_addr = 3; wr_data = 19'h7FFFF;
    tick();
    idle_in(); rd_addr1 = 3;
    #1;
    chk("r3_before_rst", 32'(rd_data1), 32'h7FFFF);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("r3_after_rst", 32'(rd_data1), 32'h0);
    chk("r3_busy_rst", 32'(rd_busy1), 32'h0);

    // Bypass
    wr_en = 1; wr_addr = 5; wr_data = 19'h12345; rd_addr1 = 5;
    #1;
    chk("bypass_data", 32'(rd_data1), 32'h12345);
    chk("bypass_busy", 32'(rd_busy1), 32'h0);
    tick();
    idle_in();
    #1;
    chk("r5_stored", 32'(rd_data1), 32'h12345);

    // Scoreboard
    iss_en = 1; iss_addr = 7;
    tick();
    idle_in(); rd_addr2 = 7;
    #1;
    chk("r7_pending", 32'(rd_busy2), 32'h1);
    wr_en = 1; wr_addr = 7; wr_data = 19'h00042;
    tick();
    idle_in();
    #1;
    chk("r7_released", 32'(rd_busy2), 32'h0);
    chk("r7_data", 32'(rd_data2), 32'h42);
    iss_en = 1; iss_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 19'h00042;
    tick();
    idle_in();
    #1;
    chk("r7_iss_wr_data", 32'(rd_data2), 32'h42);
    chk("r7_iss_wr_busy", 32'(rd_busy2), 32'h1);

    // Zero register
    wr_en = 1; wr_addr = 0; wr_data = 19'h5A5A5;
    iss_en = 1; iss_addr = 0; rd_addr1 = 0;
    #1;
    chk("r0_no_bypass", 32'(rd_data1), 32'h0);
    tick();
    idle_in();
    #1;
    chk("r0_data", 32'(rd_data1), 32'h0);
    chk("r0_busy", 32'(rd_busy1), 32'h0);

    // Full clear, writes during clear must be dropped
    fill_and_issue();
    clr_req = 1;
    tick();
    clr_req = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      wr_en = 1; wr_addr = AW'($urandom); wr_data = DW'($urandom);
      iss_en = 1; iss_addr = AW'($urandom); clr_req = 1;
      rd_addr1 = AW'($urandom); rd_addr2 = AW'($urandom);
      tick();
    end
    idle_in();
    chk("clr_cycles", 32'(n), 32'd16);
    check_all_zero("after_clr");

    // Reset in the middle of a clear
    fill_and_issue();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (7) tick();
    chk("mid_clr_busy", 32'(clr_busy), 32'h1);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("rst_mid_clr_idle", 32'(clr_busy), 32'h0);
    check_all_zero("rst_mid_clr");

    // Second build: 32-bit, 24 regs, no bypass, R0 ordinary
    b_wr_en = 1; b_wr_addr = 23; b_wr_data = 32'hFFFFFFFF; b_rd_addr1 = 23;
    #1;
    chk("b_no_bypass", b_rd_data1, 32'h0);
    tick();
    idle_in();
    #1;
    chk("b_r23", b_rd_data1, 32'hFFFFFFFF);
    b_wr_en = 1; b_wr_addr = 24; b_wr_data = 32'h1234;
    b_iss_en = 1; b_iss_addr = 24; b_rd_addr2 = 24;
    tick();
    idle_in();
    #1;
    chk("b_r24_data", b_rd_data2, 32'h0);
    chk("b_r24_busy", 32'(b_rd_busy2), 32'h0);
    b_wr_en = 1; b_wr_addr = 0; b_wr_data = 32'hABCD;
    tick();
    idle_in(); b_rd_addr1 = 0;
    #1;
    chk("b_r0", b_rd_data1, 32'hABCD);
    b_clr_req = 1;
    tick();
    b_clr_req = 0;
    n = 0;
    while (b_clr_busy === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    chk("b_clr_cycles", 32'(n), 32'd24);
    b_rd_addr1 = 23;
    #1;
    chk("b_r23_cleared", b_rd_data1, 32'h0);

    // Random traffic against the model
    repeat (3000) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      rd_addr1 = AW'($urandom);
      rd_addr2 = ($urandom_range(0, 4) == 0) ? rd_addr1 : AW'($urandom);
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = ($urandom_range(0, 2) == 0) ? rd_addr1 : AW'($urandom);
      wr_data  = DW'($urandom);
      iss_en   = ($urandom_range(0, 3) == 0);
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      clr_req  = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst_n = 1;
    idle_in();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
